core5_cpu_5_oci_dct_packer: RTL

CORE5_CPU_5_OCI_DCT_PACKER -- requirements
Module: core5_cpu_5_oci_dct_packer

---
 rtl/core5_oci_pkg.sv | 21 ++
 rtl/core5_cpu_5_oci_dct_packer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/core5_oci_pkg.sv
// Shared OCI trace definitions: DCT packer state encoding and default geometry.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package core5_oci_pkg;

   // Packer control states.
   typedef enum logic [1:0] {
      DCT_FILL  = 2'd0,
      DCT_EMIT  = 2'd1,
      DCT_ENDED = 2'd2
   } dct_state_t;

   // Default frame geometry: 15 atoms of 2 bits each.
   localparam int DCT_ATOM_W = 2;
   localparam int DCT_DEPTH  = 15;
   localparam int DCT_CNT_W  = 4;

   // Width of the optional dropped-atom counter.
   localparam int DCT_DROP_W = 16;

endpackage

// File: rtl/core5_cpu_5_oci_dct_packer.sv
// Packs trace atoms into DEPTH-atom frames and hands each frame downstream.
// Latency: frame_valid rises the cycle after the filling atom or the flush/end request.
// Backpressure: none to the atom source; atoms seen while a frame waits for frame_ready are dropped.
// Optional macro DCT_DROP_CNT_EN adds the saturating drop_count output.
module core5_cpu_5_oci_dct_packer
   import core5_oci_pkg::*;
#(
   parameter int ATOM_W = DCT_ATOM_W,
   parameter int DEPTH  = DCT_DEPTH,
   parameter int CNT_W  = DCT_CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     trace_enable,
   input  logic                     atom_valid,
   input  logic [ATOM_W-1:0]        atom_data,
   input  logic                     flush,
   input  logic                     end_req,
   output logic                     frame_valid,
   input  logic                     frame_ready,
   output logic [ATOM_W*DEPTH-1:0]  frame_data,
   output logic [CNT_W-1:0]         frame_count,
   output logic [ATOM_W*DEPTH-1:0]  dct_buffer,
   output logic [CNT_W-1:0]         dct_count,
`ifdef DCT_DROP_CNT_EN
   output logic [DCT_DROP_W-1:0]    drop_count,
`endif
   output logic                     test_ending,
   output logic                     test_has_ended
);

   localparam int BUF_W = ATOM_W * DEPTH;

   dct_state_t       state;
   logic             end_pending;

   logic             atom_acc;
   logic [CNT_W-1:0] cnt_inc;
   logic             fill_full;
   logic             has_data;
   logic             frame_acc;
   logic             go_ended;
   logic             go_emit;

   // Decode this cycle's atom acceptance and FILL exit conditions.
   always_comb begin
      atom_acc  = atom_valid & trace_enable;
      cnt_inc   = dct_count + CNT_W'(1);
      fill_full = atom_acc && (cnt_inc == CNT_W'(DEPTH));
      // A same-cycle atom counts as data, so it rides along with a flush or end.
      has_data  = (dct_count != '0) || atom_acc;
      frame_acc = (state == DCT_EMIT) && frame_ready;
      go_ended  = (state == DCT_FILL) && end_req && !has_data;
      go_emit   = (state == DCT_FILL) && !go_ended &&
                  (fill_full || ((flush || end_req) && has_data));
   end

   // The frame port is a direct view of the live buffer while EMIT holds it stable.
   always_comb begin
      frame_valid = (state == DCT_EMIT);
      frame_data  = dct_buffer;
      frame_count = dct_count;
   end

   // Shift register: accept atoms only while filling, clear once a frame is taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         dct_buffer <= '0;
         dct_count  <= '0;
      end else if (state == DCT_FILL && atom_acc) begin
         dct_buffer <= {dct_buffer[BUF_W-ATOM_W-1:0], atom_data};
         dct_count  <= cnt_inc;
      end else if (frame_acc) begin
         dct_buffer <= '0;
         dct_count  <= '0;
      end
   end

   // Control FSM plus the end-of-trace handshake flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= DCT_FILL;
         end_pending    <= 1'b0;
         test_ending    <= 1'b0;
         test_has_ended <= 1'b0;
      end else begin
         case (state)
            DCT_FILL: begin
               if (go_ended) begin
                  // Nothing to flush: end immediately, test_ending pulses one cycle.
                  state       <= DCT_ENDED;
                  test_ending <= 1'b1;
               end else if (go_emit) begin
                  state <= DCT_EMIT;
                  if (end_req) begin
                     end_pending <= 1'b1;
                     test_ending <= 1'b1;
                  end
               end
            end
            DCT_EMIT: begin
               if (frame_ready) begin
                  if (end_pending) begin
                     state          <= DCT_ENDED;
                     end_pending    <= 1'b0;
                     test_ending    <= 1'b0;
                     test_has_ended <= 1'b1;
                  end else begin
                     state <= DCT_FILL;
                  end
               end
            end
            DCT_ENDED: begin
               // Only reached with test_ending still high on the empty-buffer path.
               if (test_ending) begin
                  test_ending    <= 1'b0;
                  test_has_ended <= 1'b1;
               end
            end
            default: begin
               state <= DCT_FILL;
            end
         endcase
      end
   end

`ifdef DCT_DROP_CNT_EN
   // Count atoms that arrive while enabled but cannot be taken; saturates at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count <= '0;
      end else if (atom_acc && (state != DCT_FILL) && (drop_count != '1)) begin
         drop_count <= drop_count + DCT_DROP_W'(1);
      end
   end
`endif

endmodule
